// File: rtl/phase_countdown_pkg.sv
// Shared types and constants for the phase countdown timer.
// Holds the phase state encoding, the default counter width and the all-zero count constant.
package phase_timer_pkg;

   localparam int PHASE_WIDTH_DEFAULT = 6;

   localparam logic [PHASE_WIDTH_DEFAULT-1:0] PHASE_ZERO = '0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } phase_state_t;

endpackage

// File: rtl/phase_countdown_if.sv
// Control/status bundle between the light-sequencing FSM (master) and the countdown (slave).
interface phase_countdown_if #(
   parameter int WIDTH = phase_timer_pkg::PHASE_WIDTH_DEFAULT
);

   logic             tick_i;
   logic             load_i;
   logic [WIDTH-1:0] load_val_i;
   logic             abort_i;
   logic [WIDTH-1:0] count_o;
   logic             busy_o;
   logic             expired_o;
   logic             load_err_o;

   modport master (
      output tick_i,
      output load_i,
      output load_val_i,
      output abort_i,
      input  count_o,
      input  busy_o,
      input  expired_o,
      input  load_err_o
   );

   modport slave (
      input  tick_i,
      input  load_i,
      input  load_val_i,
      input  abort_i,
      output count_o,
      output busy_o,
      output expired_o,
      output load_err_o
   );

endinterface

// File: rtl/phase_countdown_dec_step.sv
// Combinational borrow-chain decrementer: bit i flips when every lower bit is zero.
// Mirror image of the carry-chain incrementer used by the up-counter timebase.
module phase_dec_step #(
   parameter int WIDTH = phase_timer_pkg::PHASE_WIDTH_DEFAULT
) (
   input  logic [WIDTH-1:0] value_i,
   output logic [WIDTH-1:0] value_o
);

   logic borrow;

   always_comb begin
      borrow  = 1'b1;
      value_o = '0;
      for (int i = 0; i < WIDTH; i++) begin
         value_o[i] = value_i[i] ^ borrow;
         borrow     = borrow & ~value_i[i];
      end
   end

endmodule

// File: rtl/phase_countdown.sv
// Loadable tick-driven down-counter timing one traffic-light phase, with a one-cycle expiry pulse.
// Define PHASE_AUTO_RELOAD_EN to make an expiring phase restart from the last accepted load value.
module phase_countdown
   import phase_timer_pkg::*;
#(
   parameter int WIDTH = PHASE_WIDTH_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   phase_countdown_if.slave  bus
);

   localparam logic [WIDTH-1:0] COUNT_ZERO = WIDTH'(PHASE_ZERO);
   localparam logic [WIDTH-1:0] COUNT_ONE  = WIDTH'(1);

   phase_state_t     state_q,    state_d;
   logic [WIDTH-1:0] count_q,    count_d;
   logic             busy_q,     busy_d;
   logic             expired_q,  expired_d;
   logic             load_err_q, load_err_d;
   logic [WIDTH-1:0] count_dec;
   logic             load_ok;
`ifdef PHASE_AUTO_RELOAD_EN
   logic [WIDTH-1:0] reload_q,   reload_d;
`endif

   phase_dec_step #(
      .WIDTH (WIDTH)
   ) u_dec (
      .value_i (count_q),
      .value_o (count_dec)
   );

   assign load_ok = bus.load_i && (bus.load_val_i != COUNT_ZERO);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         count_q    <= COUNT_ZERO;
         busy_q     <= 1'b0;
         expired_q  <= 1'b0;
         load_err_q <= 1'b0;
`ifdef PHASE_AUTO_RELOAD_EN
         reload_q   <= COUNT_ZERO;
`endif
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         busy_q     <= busy_d;
         expired_q  <= expired_d;
         load_err_q <= load_err_d;
`ifdef PHASE_AUTO_RELOAD_EN
         reload_q   <= reload_d;
`endif
      end
   end

   // Priority abort > accepted load > tick; a rejected zero load only flags and lets ticks proceed.
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      busy_d     = busy_q;
      expired_d  = 1'b0;
      load_err_d = 1'b0;
`ifdef PHASE_AUTO_RELOAD_EN
      reload_d   = reload_q;
`endif
      if (bus.abort_i) begin
         state_d = IDLE;
         count_d = COUNT_ZERO;
         busy_d  = 1'b0;
`ifdef PHASE_AUTO_RELOAD_EN
         reload_d = COUNT_ZERO;
`endif
      end else if (load_ok) begin
         state_d = RUN;
         count_d = bus.load_val_i;
         busy_d  = 1'b1;
`ifdef PHASE_AUTO_RELOAD_EN
         reload_d = bus.load_val_i;
`endif
      end else begin
         load_err_d = bus.load_i;
         case (state_q)
            IDLE: begin
               busy_d = 1'b0;
            end
            RUN: begin
               if (bus.tick_i) begin
                  if (count_q > COUNT_ONE) begin
                     count_d = count_dec;
                  end else begin
                     expired_d = 1'b1;
`ifdef PHASE_AUTO_RELOAD_EN
                     count_d = reload_q;
                     state_d = RUN;
                     busy_d  = 1'b1;
`else
                     count_d = COUNT_ZERO;
                     state_d = DONE;
                     busy_d  = 1'b0;
`endif
                  end
               end
            end
            DONE: begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
            default: begin
               state_d = IDLE;
               count_d = COUNT_ZERO;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   assign bus.count_o    = count_q;
   assign bus.busy_o     = busy_q;
   assign bus.expired_o  = expired_q;
   assign bus.load_err_o = load_err_q;

endmodule

// File: tb/tb_phase_countdown.sv
// Self-checking bench for phase_countdown: directed phase scenarios followed by random traffic,
// compared against a behavioural model that tracks only "phase active" and "ticks remaining".
module tb_phase_countdown;

   localparam int W = 6;

   logic clk = 1'b0;
   logic reset;

   phase_countdown_if #(.WIDTH(W)) bus ();

   phase_countdown #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int total  = 0;
   int bad    = 0;
   int stepNo = 0;

   bit mActive;
   int mRem;
   bit mExpired;
   bit mLoadErr;
`ifdef PHASE_AUTO_RELOAD_EN
   int mReload;
`endif

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s step=%0d observed=%0d expected=%0d", tag, stepNo, observed, expected);
      end
   endtask

   // Phase model: a running phase has some ticks left; each tick removes one, the last one expires it.
   task automatic modelStep(input bit r, input bit a, input bit l, input int lv, input bit t);
      mExpired = 1'b0;
      mLoadErr = 1'b0;
      if (r || a) begin
         mActive = 1'b0;
         mRem    = 0;
`ifdef PHASE_AUTO_RELOAD_EN
         mReload = 0;
`endif
      end else if (l && lv != 0) begin
         mActive = 1'b1;
         mRem    = lv;
`ifdef PHASE_AUTO_RELOAD_EN
         mReload = lv;
`endif
      end else begin
         if (l) mLoadErr = 1'b1;
         if (mActive && t) begin
            mRem = mRem - 1;
            if (mRem == 0) begin
               mExpired = 1'b1;
`ifdef PHASE_AUTO_RELOAD_EN
               mRem = mReload;
`else
               mActive = 1'b0;
`endif
            end
         end
      end
   endtask

   task automatic applyStimulus(input bit r, input bit a, input bit l, input int lv, input bit t);
      int lvMasked;
      lvMasked          = lv % (1 << W);
      reset             = r;
      bus.abort_i       = a;
      bus.load_i        = l;
      bus.load_val_i    = lvMasked[W-1:0];
      bus.tick_i        = t;
      @(posedge clk);
      modelStep(r, a, l, lvMasked, t);
      stepNo++;
      #1;
      checkOutput("count",    {26'b0, bus.count_o}, mRem);
      checkOutput("busy",     {31'b0, bus.busy_o},     {31'b0, mActive});
      checkOutput("expired",  {31'b0, bus.expired_o},  {31'b0, mExpired});
      checkOutput("load_err", {31'b0, bus.load_err_o}, {31'b0, mLoadErr});
   endtask

   initial begin
      reset          = 1'b1;
      bus.tick_i     = 1'b0;
      bus.load_i     = 1'b0;
      bus.load_val_i = '0;
      bus.abort_i    = 1'b0;
      mActive        = 1'b0;
      mRem           = 0;
      mExpired       = 1'b0;
      mLoadErr       = 1'b0;
`ifdef PHASE_AUTO_RELOAD_EN
      mReload        = 0;
`endif

      $display("[TB] reset");
      applyStimulus(1, 0, 1, 9, 1);
      checkOutput("rst_count", {26'b0, bus.count_o}, 0);
      checkOutput("rst_busy",  {31'b0, bus.busy_o}, 0);
      applyStimulus(0, 0, 0, 0, 1);

      $display("[TB] reset mid-run");
      applyStimulus(0, 0, 1, 10, 0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1);
      applyStimulus(1, 0, 0, 0, 1);
      checkOutput("midrst_count",   {26'b0, bus.count_o}, 0);
      checkOutput("midrst_expired", {31'b0, bus.expired_o}, 0);
      applyStimulus(0, 0, 0, 0, 1);

      $display("[TB] basic countdown");
      applyStimulus(0, 0, 1, 5, 1);
      for (int i = 0; i < 7; i++) applyStimulus(0, 0, 0, 0, 1);

      $display("[TB] gated ticks");
      applyStimulus(0, 1, 0, 0, 0);
      applyStimulus(0, 0, 1, 3, 0);
      applyStimulus(0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0);

      $display("[TB] boundaries");
      applyStimulus(0, 1, 0, 0, 0);
      applyStimulus(0, 0, 1, 63, 1);
      for (int i = 0; i < 65; i++) applyStimulus(0, 0, 0, 0, 1);
      applyStimulus(0, 1, 0, 0, 0);
      applyStimulus(0, 0, 1, 1, 1);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1);
      applyStimulus(0, 1, 0, 0, 0);
      applyStimulus(0, 0, 1, 0, 1);
      checkOutput("zero_load_err",   {31'b0, bus.load_err_o}, 1);
      checkOutput("zero_load_count", {26'b0, bus.count_o}, 0);
      checkOutput("zero_load_busy",  {31'b0, bus.busy_o}, 0);
      applyStimulus(0, 0, 0, 0, 1);

      $display("[TB] load on final tick");
      applyStimulus(0, 0, 1, 3, 0);
      applyStimulus(0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 1);
      applyStimulus(0, 0, 1, 4, 1);
      checkOutput("reload_last_count",   {26'b0, bus.count_o}, 4);
      checkOutput("reload_last_expired", {31'b0, bus.expired_o}, 0);
      for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 1);

      $display("[TB] abort on final tick");
      applyStimulus(0, 0, 1, 2, 0);
      applyStimulus(0, 0, 0, 0, 1);
      applyStimulus(0, 1, 0, 0, 1);
      checkOutput("abort_last_count",   {26'b0, bus.count_o}, 0);
      checkOutput("abort_last_expired", {31'b0, bus.expired_o}, 0);
      checkOutput("abort_last_busy",    {31'b0, bus.busy_o}, 0);
      applyStimulus(0, 0, 0, 0, 1);

      $display("[TB] zero load while running");
      applyStimulus(0, 0, 1, 3, 0);
      applyStimulus(0, 0, 1, 0, 1);
      applyStimulus(0, 0, 0, 0, 1);
      applyStimulus(0, 0, 1, 0, 1);
      applyStimulus(0, 0, 0, 0, 1);

      $display("[TB] repeating short phase then abort");
      applyStimulus(0, 1, 0, 0, 0);
      applyStimulus(0, 0, 1, 2, 1);
      for (int i = 0; i < 7; i++) applyStimulus(0, 0, 0, 0, 1);
      applyStimulus(0, 1, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 1);

      $display("[TB] random traffic");
      for (int i = 0; i < 800; i++) begin
         bit r, a, l, t;
         int lv;
         r  = ($urandom_range(0, 149) == 0);
         a  = ($urandom_range(0, 39) == 0);
         l  = ($urandom_range(0, 9) == 0);
         t  = ($urandom_range(0, 3) != 0);
         lv = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 63));
         applyStimulus(r, a, l, lv, t);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/phase_countdown.md
Name: phase_countdown

Overview:
Loadable down-counter that times one traffic-light phase (green, yellow or red dwell) in ticks.
- Controller loads a dwell count; block decrements once per enabled cycle and emits a one-cycle expiry pulse at zero.
- Sits between the light-sequencing FSM and the free-running up-counter timebase; it is the countdown complement of that up-counter.

Parameters:
WIDTH, 6, counter width in bits; dwell range is 1 to 2^WIDTH-1 ticks.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
tick  input  1  decrement enable (timebase strobe); count changes only when tick=1.
load  input  1  one-cycle request to start a phase.
load_val  input  WIDTH  dwell value, sampled when load=1.
abort  input  1  cancel the current phase.
count  output  WIDTH  remaining ticks (registered).
busy  output  1  high while a phase is running.
expired  output  1  one-cycle pulse when a phase reaches zero.
load_err  output  1  one-cycle pulse when load is ignored because load_val=0.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, count=0, busy=0, expired=0, load_err=0.
  - Reset overrides every other input on the same edge.
- States: IDLE, RUN, DONE. All outputs are registered.
- Input priority each edge: reset > abort > load > tick.
- IDLE:
  - load=1 with load_val!=0 -> count=load_val, state RUN, busy=1 on the next cycle.
  - load=1 with load_val=0 -> stay IDLE, load_err=1 for one cycle, count unchanged.
- RUN:
  - tick=1 and count>1 -> count=count-1.
  - tick=1 and count=1 -> count=0, state DONE, expired=1, busy=0.
  - tick=0 -> count holds.
- DONE: lasts exactly one cycle with expired=1, then IDLE. count stays 0.
- Load in RUN or DONE restarts the phase: count=load_val, state RUN. No expired pulse for the cancelled phase, even if tick=1 and count=1 on that edge.
- Load with load_val=0 in RUN: load_err=1 and the load is ignored; tick processing continues normally on that edge.
- abort in any state: count=0, state IDLE, busy=0. No expired pulse, even if it coincides with the final tick.
- Timing: load at edge k with value N and tick held high gives count=N after k, N-1 after k+1, and so on. expired is high in the cycle after edge k+N.
- Arithmetic:
  - Decrement is modulo-free: count never wraps below 0.
  - A tick in IDLE or DONE has no effect.
  - load_val is WIDTH bits, so no width truncation occurs.
- expired and load_err are never high in the same cycle, except when a zero-value load coincides with natural expiry.

Optional Feature:
PHASE_AUTO_RELOAD_EN
- Defined:
  - Block keeps a reload register, written on every accepted load.
  - On natural expiry, count reloads from it and the state stays RUN instead of entering DONE. busy stays 1.
  - expired still pulses for one cycle on each expiry.
  - abort clears the reload register to 0 and returns to IDLE.
- Undefined: no reload register; behaviour is exactly as above.

Decomposition:
- Package phase_timer_pkg:
  - typedef enum phase_state_t {IDLE, RUN, DONE}.
  - localparam PHASE_WIDTH_DEFAULT=6.
  - localparam PHASE_ZERO (all-zero count constant).
- One sub-module, phase_dec_step: combinational WIDTH-bit borrow-chain decrementer.
  - Bit i toggles when all lower bits are 0; bit 0 always toggles.
  - This is the mirror of the team's carry-chain up-counter.
  - The top level instantiates it for count-1.

Test Plan:
- Reset mid-RUN: load 10, 3 ticks (count=7), assert reset 1 cycle -> count=0, busy=0, state IDLE next cycle, no expired pulse.
- Basic countdown: load 5, tick held high -> count 5,4,3,2,1,0, busy falls and expired=1 exactly one cycle, then IDLE.
- Gated ticks: load 3, tick pattern 1,0,0,1,0,1 -> count 3,2,2,2,1,1,0, expired after the 3rd tick only.
- Boundaries:
  - load 63 with ticks -> expired after 63 ticks.
  - load 1 -> expired one tick later.
  - load 0 -> load_err pulse, stays IDLE, count 0.
- Simultaneous events:
  - count=1 with tick and load 4 together -> count=4, RUN, no expired.
  - count=1 with tick and abort together -> IDLE, count=0, no expired.
- PHASE_AUTO_RELOAD_EN build: load 2, tick held -> count 2,1,2,1,2…, expired pulses every 2 ticks, busy stays 1. abort -> IDLE, and a later tick does nothing.
